// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, EX redirect and
// data-memory wait handling with a handshake timeout and saturating perf counters.
//
// state  | meaning
// S_RUN  | normal issue, no memory wait in progress
// S_WAIT | MEM stage waiting for mem_ready, wait_cnt counts stalled cycles
// S_ERR  | memory handshake timed out, pipeline frozen until reset
module pipe_hazard_ctrl #(
  parameter int MEM_TMO = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TMO + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              memstall;
  logic              load_use;
  logic              redirect_ok;

  assign memstall = mem_req & ~mem_ready;

  assign load_use = ex_is_load & ex_rf_we & (ex_rd != 5'd0) &
                    ((id_re1 & (id_rs1 == ex_rd)) | (id_re2 & (id_rs2 == ex_rd)));

  assign redirect_ok = (state != S_ERR) & ~memstall & ex_redirect;

  // Redirect outranks load-use: the ID instruction is discarded anyway.
  always_comb begin
    pc_hold      = 1'b0;
    ifid_hold    = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if ((state == S_ERR) || memstall) begin
      pc_hold      = 1'b1;
      ifid_hold    = 1'b1;
      idex_hold    = 1'b1;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (memstall) begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        S_WAIT: begin
          if (!memstall) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TMO)) begin
            state   <= S_ERR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state    <= S_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_ok && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand-written multi-cycle
// sequences, and random traffic checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TMO = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_re1, id_re2, ex_rf_we, ex_is_load, ex_redirect;
  logic             mem_req, mem_ready;
  logic             pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic             ifid_flush, idex_flush, memwb_bubble, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0]       ctl;

  pipe_hazard_ctrl #(.MEM_TMO(MEM_TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_re1(id_re1), .id_re2(id_re2),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
    .exmem_hold(exmem_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_bubble(memwb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, bubble}
  assign ctl = {pc_hold, ifid_hold, idex_hold, exmem_hold,
                ifid_flush, idex_flush, memwb_bubble};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_err;
  int m_consec, m_stall, m_flush;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       re1, re2;
    logic [4:0] rd;
    logic       we, ld, redir, mreq, mrdy;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_re1 = 0; id_re2 = 0; ex_rd = 0;
    ex_rf_we = 0; ex_is_load = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Called 1 time unit after a rising edge; releases reset well before the next edge.
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    m_err = 0; m_consec = 0; m_stall = 0; m_flush = 0;
    #2 rst = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_is_load = 1; ex_rf_we = 1; ex_rd = rd; id_rs2 = rd; id_re2 = 1;
  endtask

  function automatic bit model_memstall();
    return mem_req && !mem_ready;
  endfunction

  function automatic bit model_load_use();
    return ex_is_load && ex_rf_we && (ex_rd != 0) &&
           ((id_re1 && id_rs1 == ex_rd) || (id_re2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [6:0] model_ctl();
    if (m_err || model_memstall()) return 7'b1111001;
    if (ex_redirect)               return 7'b0000110;
    if (model_load_use())          return 7'b1100010;
    return 7'b0000000;
  endfunction

  task automatic model_cycle();
    logic [6:0] exp;
    bit ms;
    @(negedge clk);
    exp = model_ctl();
    ms  = model_memstall();
    check("ctl", int'(ctl), int'(exp));
    @(posedge clk);
    if (exp[6]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
    if (!m_err && !ms && ex_redirect) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
    if (!m_err) begin
      if (ms) begin
        m_consec++;
        if (m_consec > MEM_TMO) m_err = 1;
      end else begin
        m_consec = 0;
      end
    end
    #1;
    check("mem_err", int'(mem_err), int'(m_err));
    check("stall_cnt", int'(stall_cnt), m_stall);
    check("flush_cnt", int'(flush_cnt), m_flush);
  endtask

  initial begin
    int rdy_pct;
    tbl[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[1] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100010};
    tbl[2] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[3] = '{5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[4] = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1100010};
    tbl[5] = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[6] = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[7] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'b0000110};
    tbl[8] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1111001};
    tbl[9] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'b1100010};

    rst = 1'b0;
    clear_inputs();
    #3;
    check("reset_ctl", int'(ctl), 0);
    check("reset_mem_err", int'(mem_err), 0);
    check("reset_stall_cnt", int'(stall_cnt), 0);
    check("reset_flush_cnt", int'(flush_cnt), 0);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      do_reset();
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; id_re1 = tbl[i].re1; id_re2 = tbl[i].re2;
      ex_rd = tbl[i].rd; ex_rf_we = tbl[i].we; ex_is_load = tbl[i].ld;
      ex_redirect = tbl[i].redir; mem_req = tbl[i].mreq; mem_ready = tbl[i].mrdy;
      @(negedge clk);
      check($sformatf("tbl%0d_ctl", i), int'(ctl), int'(tbl[i].exp));
      @(posedge clk); #1;
    end

    // Single load-use costs one stall; rd=0 never stalls.
    do_reset();
    set_load_use(5'd5);
    @(posedge clk); #1;
    clear_inputs();
    check("lu_stall_cnt", int'(stall_cnt), 1);
    set_load_use(5'd0);
    @(negedge clk);
    check("lu_rd0_ctl", int'(ctl), 0);
    @(posedge clk); #1;
    check("lu_rd0_stall_cnt", int'(stall_cnt), 1);

    // Redirect wins over load-use.
    do_reset();
    set_load_use(5'd5);
    ex_redirect = 1;
    @(posedge clk); #1;
    clear_inputs();
    check("redir_flush_cnt", int'(flush_cnt), 1);
    check("redir_stall_cnt", int'(stall_cnt), 0);

    // Three-cycle memory wait, then a fresh wait must not inherit the old count.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("memwait%0d_ctl", i), int'(ctl), 7'b1111001);
      @(posedge clk); #1;
    end
    mem_ready = 1;
    @(negedge clk);
    check("memwait_done_ctl", int'(ctl), 0);
    @(posedge clk); #1;
    check("memwait_stall_cnt", int'(stall_cnt), 3);
    mem_ready = 0;
    repeat (MEM_TMO) @(posedge clk);
    #1;
    check("memwait_restart_no_err", int'(mem_err), 0);

    // Timeout after MEM_TMO+1 stalled edges; ERR persists; async reset clears it.
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= MEM_TMO + 1; i++) begin
      @(posedge clk); #1;
      check($sformatf("tmo_edge%0d_mem_err", i), int'(mem_err), (i == MEM_TMO + 1) ? 1 : 0);
    end
    mem_ready = 1;
    @(negedge clk);
    check("err_ctl_held", int'(ctl), 7'b1111001);
    #2 rst = 1'b0;
    #1;
    check("async_rst_mem_err", int'(mem_err), 0);
    check("async_rst_stall_cnt", int'(stall_cnt), 0);
    check("async_rst_flush_cnt", int'(flush_cnt), 0);
    check("async_rst_ctl", int'(ctl), 0);
    @(posedge clk); #1;

    // Stall counter saturation.
    do_reset();
    set_load_use(5'd9);
    repeat (9) @(posedge clk);
    #1;
    check("sat_stall_cnt", int'(stall_cnt), CNT_MAX);

    // Random traffic against the reference model.
    do_reset();
    rdy_pct = 90;
    for (int n = 0; n < 800; n++) begin
      if (n % 40 == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 90;
          1:       rdy_pct = 50;
          default: rdy_pct = 10;
        endcase
      end
      if ($urandom_range(0, 99) < 2) do_reset();
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_re1      = 1'($urandom_range(0, 1));
      id_re2      = 1'($urandom_range(0, 1));
      ex_rf_we    = 1'($urandom_range(0, 1));
      ex_is_load  = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 4) == 0);
      mem_req     = ($urandom_range(0, 2) != 0);
      mem_ready   = ($urandom_range(0, 99) < rdy_pct);
      model_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
